// File: rtl/stage_if_if.sv
// Fetch-stage bus: icache/iTLB lookup, fill and redirect inputs, IFID outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; the IFID side updates every cycle.
interface stage_if_if #(
  parameter int N_THREADS = 4
);
  localparam int TW = $clog2(N_THREADS);

  // lookup request / same-cycle response
  logic                       ic_req_valid;
  logic [31:0]                ic_req_addr;
  logic                       ic_rsp_hit;
  logic                       ic_rsp_miss;
  logic                       ic_rsp_itlb_miss;
  logic [31:0]                ic_rsp_data;
  // fill completion
  logic                       ic_fill_done;
  logic [TW-1:0]              ic_fill_thread;
  // writeback redirect
  logic                       wb_redirect_en;
  logic [TW-1:0]              wb_redirect_thread;
  logic [31:0]                wb_redirect_pc;
  // per-thread rm4 values
  logic [N_THREADS-1:0][31:0] rm4;
  // IFID outputs
  logic [31:0]                if_pc;
  logic [31:0]                if_instruction;
  logic [TW-1:0]              if_thread;
  logic                       if_itlb_miss;
  logic                       if_icache_miss;
  logic [31:0]                if_rm4;

  // fetch stage side
  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_rsp_hit, ic_rsp_miss, ic_rsp_itlb_miss, ic_rsp_data,
    input  ic_fill_done, ic_fill_thread,
    input  wb_redirect_en, wb_redirect_thread, wb_redirect_pc,
    input  rm4,
    output if_pc, if_instruction, if_thread, if_itlb_miss, if_icache_miss, if_rm4
  );

  // cache / writeback / decode side
  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_rsp_hit, ic_rsp_miss, ic_rsp_itlb_miss, ic_rsp_data,
    output ic_fill_done, ic_fill_thread,
    output wb_redirect_en, wb_redirect_thread, wb_redirect_pc,
    output rm4,
    input  if_pc, if_instruction, if_thread, if_itlb_miss, if_icache_miss, if_rm4
  );
endinterface

// File: rtl/stage_if.sv
// Multithreaded instruction fetch: round-robin pick of a READY thread, iTLB/icache lookup, IFID register.
// Latency: lookup in cycle N, IFID outputs registered at the end of cycle N.
// Backpressure: none; a parked-everything cycle emits a bubble instead of stalling.
module stage_if #(
  parameter int          N_THREADS = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  stage_if_if.master bus
);
  localparam int TW = $clog2(N_THREADS);

  typedef enum logic [1:0] {
    TH_READY      = 2'd0,
    TH_WAIT_FILL  = 2'd1,
    TH_WAIT_REDIR = 2'd2
  } th_state_e;

  th_state_e     state_q [N_THREADS];
  th_state_e     state_d [N_THREADS];
  logic [31:0]   pc_q    [N_THREADS];
  logic [31:0]   pc_d    [N_THREADS];
  logic [TW-1:0] ptr_q, ptr_d;

  logic [31:0]   if_pc_q, if_pc_d;
  logic [31:0]   if_instr_q, if_instr_d;
  logic [TW-1:0] if_thread_q, if_thread_d;
  logic          if_itlb_q, if_itlb_d;
  logic          if_icm_q, if_icm_d;
  logic [31:0]   if_rm4_q, if_rm4_d;

  logic [N_THREADS-1:0] eligible;
  logic                 grant_vld;
  logic [TW-1:0]        grant_id;
  logic [TW-1:0]        cand;

  // A thread may fetch if READY and not being redirected this very cycle
  always_comb begin
    for (int t = 0; t < N_THREADS; t++) begin
      eligible[t] = (state_q[t] == TH_READY) &&
                    !(bus.wb_redirect_en && (bus.wb_redirect_thread == TW'(t)));
    end
  end

  // Round-robin scan starting just after the last granted thread
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ptr_q;
    cand      = '0;
    for (int i = 1; i <= N_THREADS; i++) begin
      cand = ptr_q + TW'(i);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign bus.ic_req_valid = grant_vld;
  assign bus.ic_req_addr  = grant_vld ? pc_q[grant_id] : 32'h0;

  // Next thread states/PCs and next IFID contents; redirect is applied last so it wins
  always_comb begin
    for (int t = 0; t < N_THREADS; t++) begin
      state_d[t] = state_q[t];
      pc_d[t]    = pc_q[t];
    end
    ptr_d       = ptr_q;
    if_pc_d     = 32'h0;
    if_instr_d  = NOP_INSTR;
    if_thread_d = ptr_q;
    if_itlb_d   = 1'b0;
    if_icm_d    = 1'b1;
    if_rm4_d    = 32'h0;

    if (grant_vld) begin
      ptr_d       = grant_id;
      if_pc_d     = pc_q[grant_id];
      if_thread_d = grant_id;
      if_rm4_d    = bus.rm4[grant_id];
      if (bus.ic_rsp_itlb_miss) begin
        if_itlb_d         = 1'b1;
        if_icm_d          = 1'b0;
        state_d[grant_id] = TH_WAIT_REDIR;
      end else if (bus.ic_rsp_miss) begin
        state_d[grant_id] = TH_WAIT_FILL;
      end else if (bus.ic_rsp_hit) begin
        if_instr_d     = bus.ic_rsp_data;
        if_icm_d       = 1'b0;
        pc_d[grant_id] = pc_q[grant_id] + 32'd4;
      end else begin
        // no response at all is handled like a miss; the cache owns the fill
        state_d[grant_id] = TH_WAIT_FILL;
      end
    end

    // the granted thread is READY, so a fill can never collide with its outcome
    if (bus.ic_fill_done && (state_q[bus.ic_fill_thread] == TH_WAIT_FILL)) begin
      state_d[bus.ic_fill_thread] = TH_READY;
    end

    if (bus.wb_redirect_en) begin
      state_d[bus.wb_redirect_thread] = TH_READY;
      pc_d[bus.wb_redirect_thread]    = bus.wb_redirect_pc;
    end
  end

  // Per-thread state, PCs and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int t = 0; t < N_THREADS; t++) begin
        state_q[t] <= TH_READY;
        pc_q[t]    <= RESET_PC;
      end
      ptr_q <= TW'(N_THREADS - 1);
    end else begin
      for (int t = 0; t < N_THREADS; t++) begin
        state_q[t] <= state_d[t];
        pc_q[t]    <= pc_d[t];
      end
      ptr_q <= ptr_d;
    end
  end

  // IFID output register; reset presents a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_pc_q     <= 32'h0;
      if_instr_q  <= NOP_INSTR;
      if_thread_q <= '0;
      if_itlb_q   <= 1'b0;
      if_icm_q    <= 1'b1;
      if_rm4_q    <= 32'h0;
    end else begin
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_thread_q <= if_thread_d;
      if_itlb_q   <= if_itlb_d;
      if_icm_q    <= if_icm_d;
      if_rm4_q    <= if_rm4_d;
    end
  end

  assign bus.if_pc          = if_pc_q;
  assign bus.if_instruction = if_instr_q;
  assign bus.if_thread      = if_thread_q;
  assign bus.if_itlb_miss   = if_itlb_q;
  assign bus.if_icache_miss = if_icm_q;
  assign bus.if_rm4         = if_rm4_q;
endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed per-cycle vectors, expected IFID values queued by the driver.
// Latency: vector applied at negedge appears on IFID after the next posedge.
// Backpressure: none; one expected entry is consumed per cycle.
module tb_stage_if;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stage_if_if #(.N_THREADS(N)) bus ();
  stage_if #(.N_THREADS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum logic [1:0] {R_HIT, R_MISS, R_TLB, R_NONE} rsp_e;

  typedef struct {
    logic        rst_n;
    rsp_e        rsp;
    logic        fill;
    logic [1:0]  fill_t;
    logic        red;
    logic [1:0]  red_t;
    logic [31:0] red_pc;
    logic        bub;
    logic [1:0]  exp_thr;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rm4;
    logic [1:0]  thr;
    logic        itlb;
    logic        icm;
    logic        chk_rm4;
  } expect_t;

  vec_t    vq[$];
  expect_t sb[$];
  rsp_e    cur_rsp = R_NONE;
  int      n_vec = 0;
  int      n_err = 0;

  // icache model: response kind from the current vector, data tagged with the address
  assign bus.ic_rsp_hit       = (cur_rsp == R_HIT);
  assign bus.ic_rsp_miss      = (cur_rsp == R_MISS);
  assign bus.ic_rsp_itlb_miss = (cur_rsp == R_TLB);
  assign bus.ic_rsp_data      = 32'hA5A5_0000 | bus.ic_req_addr;

  task automatic v(input logic rst_n, input rsp_e rsp, input logic fill, input logic [1:0] fill_t,
                   input logic red, input logic [1:0] red_t, input logic [31:0] red_pc,
                   input logic bub, input logic [1:0] thr, input logic [31:0] pc);
    vec_t x;
    x.rst_n = rst_n; x.rsp = rsp; x.fill = fill; x.fill_t = fill_t;
    x.red = red; x.red_t = red_t; x.red_pc = red_pc;
    x.bub = bub; x.exp_thr = thr; x.exp_pc = pc;
    vq.push_back(x);
  endtask

  function automatic expect_t mk_exp(input vec_t x);
    expect_t e;
    e.pc = 32'h0; e.instr = 32'h0; e.rm4 = 32'h0; e.thr = 2'd0;
    e.itlb = 1'b0; e.icm = 1'b1; e.chk_rm4 = 1'b1;
    if (x.rst_n && x.bub) begin
      e.thr     = x.exp_thr;
      e.chk_rm4 = 1'b0;
    end else if (x.rst_n) begin
      e.pc  = x.exp_pc;
      e.thr = x.exp_thr;
      e.rm4 = 32'hC0DE_0000 + {30'd0, x.exp_thr};
      case (x.rsp)
        R_HIT:   begin e.instr = 32'hA5A5_0000 | x.exp_pc; e.icm = 1'b0; end
        R_TLB:   begin e.itlb = 1'b1; e.icm = 1'b0; end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", name, n_vec, act, exp_v);
    end
  endtask

  // monitor: one IFID word per cycle, compared against the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      expect_t e;
      e = sb.pop_front();
      chk("if_pc",          bus.if_pc,                   e.pc);
      chk("if_instruction", bus.if_instruction,          e.instr);
      chk("if_thread",      {30'd0, bus.if_thread},      {30'd0, e.thr});
      chk("if_itlb_miss",   {31'd0, bus.if_itlb_miss},   {31'd0, e.itlb});
      chk("if_icache_miss", {31'd0, bus.if_icache_miss}, {31'd0, e.icm});
      if (e.chk_rm4) chk("if_rm4", bus.if_rm4, e.rm4);
      n_vec++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ic_fill_done       = 1'b0;
    bus.ic_fill_thread     = 2'd0;
    bus.wb_redirect_en     = 1'b0;
    bus.wb_redirect_thread = 2'd0;
    bus.wb_redirect_pc     = 32'h0;
    for (int t = 0; t < N; t++) bus.rm4[t] = 32'hC0DE_0000 + t;

    //  rst   rsp     fill ft  red rt  red_pc         bub thr pc
    // reset and plain rotation
    v(1'b0, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h0);
    v(1'b0, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h0);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  1, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  2, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  3, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h1004);
    // icache miss on thread 1, then fill
    v(1'b0, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h0);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h1000);
    v(1'b1, R_MISS, 0, 0,   0, 0, 32'h0,          0,  1, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  2, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  3, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h1004);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  2, 32'h1004);
    v(1'b1, R_HIT,  1, 1,   0, 0, 32'h0,          0,  3, 32'h1004);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h1008);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  1, 32'h1000);
    // iTLB miss on thread 2, fill ignored, redirect resumes it
    v(1'b1, R_TLB,  0, 0,   0, 0, 32'h0,          0,  2, 32'h1008);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  3, 32'h1008);
    v(1'b1, R_HIT,  1, 2,   0, 0, 32'h0,          0,  0, 32'h100C);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  1, 32'h1004);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  3, 32'h100C);
    v(1'b1, R_HIT,  0, 0,   1, 2, 32'h2000,       0,  0, 32'h1010);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  1, 32'h1008);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  2, 32'h2000);
    // park every thread, bubbles, fill+redirect on thread 3
    v(1'b1, R_MISS, 0, 0,   0, 0, 32'h0,          0,  3, 32'h1010);
    v(1'b1, R_MISS, 0, 0,   0, 0, 32'h0,          0,  0, 32'h1014);
    v(1'b1, R_MISS, 0, 0,   0, 0, 32'h0,          0,  1, 32'h100C);
    v(1'b1, R_MISS, 0, 0,   0, 0, 32'h0,          0,  2, 32'h2004);
    v(1'b1, R_NONE, 0, 0,   0, 0, 32'h0,          1,  2, 32'h0);
    v(1'b1, R_NONE, 0, 0,   0, 0, 32'h0,          1,  2, 32'h0);
    v(1'b1, R_NONE, 1, 3,   1, 3, 32'h3000,       1,  2, 32'h0);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  3, 32'h3000);
    // redirect of the only READY thread excludes it from this cycle's scan
    v(1'b1, R_HIT,  0, 0,   1, 3, 32'h4000,       1,  3, 32'h0);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  3, 32'h4000);
    // PC wrap on thread 0
    v(1'b1, R_HIT,  0, 0,   1, 0, 32'hFFFF_FFFC,  0,  3, 32'h4004);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'hFFFF_FFFC);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  3, 32'h4008);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h0000_0000);
    // reset while threads 1 and 2 are parked; stale fill ignored
    v(1'b0, R_HIT,  0, 0,   0, 0, 32'h0,          0,  0, 32'h0);
    v(1'b1, R_HIT,  1, 1,   0, 0, 32'h0,          0,  0, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  1, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  2, 32'h1000);
    v(1'b1, R_HIT,  0, 0,   0, 0, 32'h0,          0,  3, 32'h1000);

    while (vq.size() > 0) begin
      vec_t x;
      x = vq.pop_front();
      @(negedge clk);
      rst                    = x.rst_n;
      cur_rsp                = x.rsp;
      bus.ic_fill_done       = x.fill;
      bus.ic_fill_thread     = x.fill_t;
      bus.wb_redirect_en     = x.red;
      bus.wb_redirect_thread = x.red_t;
      bus.wb_redirect_pc     = x.red_pc;
      sb.push_back(mk_exp(x));
    end

    @(negedge clk);
    cur_rsp            = R_NONE;
    bus.ic_fill_done   = 1'b0;
    bus.wb_redirect_en = 1'b0;
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
